// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pkg
// Description : Shared constants for the Mandelbrot result path: screen
//               geometry, result bus field layout and collector FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int NUM_ENGINES = 16;
    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int FB_ADDR_W   = 19;

    // Result bus layout: {x[9:0], y[8:0], itr[7:0]}
    localparam int RESULT_W = 27;
    localparam int X_MSB    = 26;
    localparam int X_LSB    = 17;
    localparam int Y_MSB    = 16;
    localparam int Y_LSB    = 8;
    localparam int ITR_MSB  = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : result_collector_if
// Description : Engine service handshake, frame buffer write port and frame
//               status signals of the result collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_collector_if #(
    parameter int NUM_ENGINES = mandel_pkg::NUM_ENGINES,
    parameter int FB_ADDR_W   = mandel_pkg::FB_ADDR_W
);

    logic [NUM_ENGINES-1:0]          service_req;
    logic [mandel_pkg::RESULT_W-1:0] result_bus;
    logic [NUM_ENGINES-1:0]          req_ack;
    logic                            fb_wr_en;
    logic                            fb_wr_ready;
    logic [FB_ADDR_W-1:0]            fb_addr;
    logic [7:0]                      fb_data;
    logic                            frame_start;
    logic [FB_ADDR_W-1:0]            pixel_count;
    logic                            frame_done;
    logic                            coord_err;

    modport master (
        input  service_req, result_bus, fb_wr_ready, frame_start,
        output req_ack, fb_wr_en, fb_addr, fb_data, pixel_count, frame_done, coord_err
    );

    modport slave (
        output service_req, result_bus, fb_wr_ready, frame_start,
        input  req_ack, fb_wr_en, fb_addr, fb_data, pixel_count, frame_done, coord_err
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first set request at or
//               after the pointer, wrapping at NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int PTR_W   = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    // One spare bit so ptr + offset cannot overflow before the wrap
    localparam int IDX_W = PTR_W + 1;

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'(ptr) + IDX_W'(i);
            if (w_idx >= IDX_W'(NUM_REQ)) begin
                w_idx = w_idx - IDX_W'(NUM_REQ);
            end
            if (enable && !grant_vld && req[w_idx[PTR_W-1:0]]) begin
                grant[w_idx[PTR_W-1:0]] = 1'b1;
                grant_idx               = w_idx[PTR_W-1:0];
                grant_vld               = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
// Module      : result_collector
// Description : Round-robin services Mandelbrot engines, captures each result
//               and writes it to the frame buffer; counts pixels per frame.
//               Optional macro MAXITR_BLACK_EN maps itr 8'hFF to black.
// Revision    : 1.0 - initial release
// ============================================================================
module result_collector #(
    parameter int NUM_ENGINES = mandel_pkg::NUM_ENGINES,
    parameter int H_RES       = mandel_pkg::H_RES,
    parameter int V_RES       = mandel_pkg::V_RES,
    parameter int FB_ADDR_W   = mandel_pkg::FB_ADDR_W
) (
    input  logic                Engine_CLK,
    input  logic                eRST,
    result_collector_if.master  bus
);

    import mandel_pkg::*;

    localparam int                   PTR_W        = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PTR_W-1:0]     LAST_ENGINE  = PTR_W'(NUM_ENGINES - 1);
    localparam logic [FB_ADDR_W-1:0] FRAME_PIXELS = FB_ADDR_W'(H_RES * V_RES);

    logic [1:0]             r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_ENGINES-1:0] w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_vld;
    logic [9:0]             w_x;
    logic [8:0]             w_y;
    logic [7:0]             w_itr;
    logic                   w_in_range;
    logic [FB_ADDR_W-1:0]   w_addr;
    logic [7:0]             w_pix;
    logic                   w_accept;

    rr_arbiter #(
        .NUM_REQ   (NUM_ENGINES),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req       (bus.service_req),
        .ptr       (r_ptr),
        .enable    (r_state == ST_IDLE),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    assign w_x        = bus.result_bus[X_MSB:X_LSB];
    assign w_y        = bus.result_bus[Y_MSB:Y_LSB];
    assign w_itr      = bus.result_bus[ITR_MSB:0];
    assign w_in_range = (32'(w_x) < 32'(H_RES)) && (32'(w_y) < 32'(V_RES));
    assign w_addr     = FB_ADDR_W'(32'(w_y) * 32'(H_RES) + 32'(w_x));
    assign w_accept   = bus.fb_wr_en && bus.fb_wr_ready;

`ifdef MAXITR_BLACK_EN
    assign w_pix = (w_itr == 8'hFF) ? 8'h00 : w_itr;
`else
    assign w_pix = w_itr;
`endif

    always_ff @(posedge Engine_CLK) begin
        if (eRST) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            bus.req_ack     <= '0;
            bus.fb_wr_en    <= 1'b0;
            bus.fb_addr     <= '0;
            bus.fb_data     <= '0;
            bus.pixel_count <= '0;
            bus.frame_done  <= 1'b0;
            bus.coord_err   <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            // A frame_start clear takes precedence over a coincident write
            if (bus.frame_start) begin
                bus.pixel_count <= '0;
            end else if (w_accept && (bus.pixel_count != FRAME_PIXELS)) begin
                bus.pixel_count <= bus.pixel_count + 1'b1;
                if (bus.pixel_count + 1'b1 == FRAME_PIXELS) begin
                    bus.frame_done <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        bus.req_ack <= w_grant;
                        r_ptr       <= (w_grant_idx == LAST_ENGINE) ? '0 : w_grant_idx + 1'b1;
                        r_state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    bus.req_ack <= '0;
                    if (w_in_range) begin
                        bus.fb_wr_en <= 1'b1;
                        bus.fb_addr  <= w_addr;
                        bus.fb_data  <= w_pix;
                        r_state      <= ST_WRITE;
                    end else begin
                        bus.coord_err <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_WRITE: begin
                    if (bus.fb_wr_ready) begin
                        bus.fb_wr_en <= 1'b0;
                        r_state      <= ST_HOLD;
                    end
                end
                // Lets the served engine drop service_req before re-arbitration
                ST_HOLD: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_collector
// Description : Directed self-checking bench for result_collector (full-size
//               instance plus a 4x2 instance for frame completion).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_collector;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    result_collector_if #(.NUM_ENGINES(16), .FB_ADDR_W(19)) ifa ();
    result_collector_if #(.NUM_ENGINES(16), .FB_ADDR_W(19)) ifs ();

    result_collector #(
        .NUM_ENGINES (16),
        .H_RES       (640),
        .V_RES       (480),
        .FB_ADDR_W   (19)
    ) dut (
        .Engine_CLK  (clk),
        .eRST        (rst),
        .bus         (ifa)
    );

    result_collector #(
        .NUM_ENGINES (16),
        .H_RES       (4),
        .V_RES       (2),
        .FB_ADDR_W   (19)
    ) dut_s (
        .Engine_CLK  (clk),
        .eRST        (rst),
        .bus         (ifs)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MAXITR_BLACK_EN
    localparam logic [7:0] C_MAX_PIX = 8'h00;
`else
    localparam logic [7:0] C_MAX_PIX = 8'hFF;
`endif

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pack(input int x, input int y, input int itr);
        return {10'(x), 9'(y), 8'(itr)};
    endfunction

    task automatic do_reset();
        rst             = 1'b1;
        ifa.service_req = '0;
        ifa.frame_start = 1'b0;
        ifa.fb_wr_ready = 1'b1;
        ifa.result_bus  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits a bounded number of cycles for any grant, then checks it
    task automatic wait_grant(input string tag, input logic [15:0] exp);
        for (int n = 0; n < 8; n++) begin
            tick();
            if (ifa.req_ack != 16'h0) break;
        end
        check_eq(tag, 64'(ifa.req_ack), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        ifs.service_req = '0;
        ifs.frame_start = 1'b0;
        ifs.fb_wr_ready = 1'b1;
        ifs.result_bus  = '0;
        do_reset();

        // Reset state
        check_eq("rst_ack",   64'(ifa.req_ack),     64'h0);
        check_eq("rst_wren",  64'(ifa.fb_wr_en),    64'h0);
        check_eq("rst_addr",  64'(ifa.fb_addr),     64'h0);
        check_eq("rst_data",  64'(ifa.fb_data),     64'h0);
        check_eq("rst_pix",   64'(ifa.pixel_count), 64'h0);
        check_eq("rst_done",  64'(ifa.frame_done),  64'h0);
        check_eq("rst_cerr",  64'(ifa.coord_err),   64'h0);

        // Single request: engine 3, x=10 y=2 itr=37 -> addr 2*640+10
        ifa.service_req = 16'h0008;
        ifa.result_bus  = pack(10, 2, 37);
        tick();
        check_eq("single_ack",      64'(ifa.req_ack),  64'h0008);
        check_eq("single_ack_wren", 64'(ifa.fb_wr_en), 64'h0);
        tick();
        check_eq("single_ack_drop", 64'(ifa.req_ack),  64'h0);
        check_eq("single_wren",     64'(ifa.fb_wr_en), 64'h1);
        check_eq("single_addr",     64'(ifa.fb_addr),  64'd1290);
        check_eq("single_data",     64'(ifa.fb_data),  64'd37);
        tick();
        check_eq("single_hold_wren", 64'(ifa.fb_wr_en),    64'h0);
        check_eq("single_pix",       64'(ifa.pixel_count), 64'd1);
        check_eq("single_hold_ack",  64'(ifa.req_ack),     64'h0);
        tick();
        check_eq("single_no_regrant", 64'(ifa.req_ack), 64'h0);
        ifa.service_req = 16'h0000;
        tick();
        check_eq("single_idle_ack", 64'(ifa.req_ack), 64'h0);

        // Round robin between engines 0 and 4
        do_reset();
        ifa.result_bus  = pack(1, 1, 2);
        ifa.service_req = 16'h0011;
        wait_grant("rr_grant0", 16'h0001);
        wait_grant("rr_grant1", 16'h0010);
        wait_grant("rr_grant2", 16'h0001);
        wait_grant("rr_grant3", 16'h0010);
        ifa.service_req = 16'h0000;

        // Backpressure: fb_wr_ready low for 5 WRITE cycles, engine 2 waiting
        do_reset();
        ifa.fb_wr_ready = 1'b0;
        ifa.service_req = 16'h0006;
        ifa.result_bus  = pack(5, 1, 9);
        tick();
        check_eq("bp_ack", 64'(ifa.req_ack), 64'h0002);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_wren_%0d", i), 64'(ifa.fb_wr_en), 64'h1);
            check_eq($sformatf("bp_addr_%0d", i), 64'(ifa.fb_addr),  64'd645);
            check_eq($sformatf("bp_data_%0d", i), 64'(ifa.fb_data),  64'd9);
            check_eq($sformatf("bp_ack_%0d",  i), 64'(ifa.req_ack),  64'h0);
            if (i < 4) tick();
        end
        ifa.fb_wr_ready = 1'b1;
        tick();
        check_eq("bp_hold_wren", 64'(ifa.fb_wr_en),    64'h0);
        check_eq("bp_hold_ack",  64'(ifa.req_ack),     64'h0);
        check_eq("bp_pix",       64'(ifa.pixel_count), 64'd1);
        tick();
        check_eq("bp_idle_ack",  64'(ifa.req_ack),     64'h0);
        tick();
        check_eq("bp_next_ack",  64'(ifa.req_ack),     64'h0004);
        ifa.service_req = 16'h0000;

        // Bad coordinate x=700, then a valid write; coord_err stays set
        do_reset();
        ifa.service_req = 16'h0001;
        ifa.result_bus  = pack(700, 5, 1);
        tick();
        ifa.service_req = 16'h0000;
        tick();
        check_eq("badx_wren", 64'(ifa.fb_wr_en),    64'h0);
        check_eq("badx_cerr", 64'(ifa.coord_err),   64'h1);
        check_eq("badx_pix",  64'(ifa.pixel_count), 64'h0);
        tick();
        check_eq("badx_idle_wren", 64'(ifa.fb_wr_en), 64'h0);
        // y = V_RES is the first out-of-range row
        ifa.service_req = 16'h0001;
        ifa.result_bus  = pack(0, 480, 1);
        tick();
        ifa.service_req = 16'h0000;
        tick();
        check_eq("bady_wren", 64'(ifa.fb_wr_en),    64'h0);
        check_eq("bady_pix",  64'(ifa.pixel_count), 64'h0);
        tick();
        // Last valid pixel, max iterations
        ifa.service_req = 16'h0020;
        ifa.result_bus  = pack(639, 479, 255);
        tick();
        ifa.service_req = 16'h0000;
        tick();
        check_eq("corner_wren", 64'(ifa.fb_wr_en),  64'h1);
        check_eq("corner_addr", 64'(ifa.fb_addr),   64'd307199);
        check_eq("corner_data", 64'(ifa.fb_data),   64'(C_MAX_PIX));
        tick();
        check_eq("corner_pix",  64'(ifa.pixel_count), 64'd1);
        check_eq("sticky_cerr", 64'(ifa.coord_err),   64'h1);
        tick();

        // Reset asserted during ACK discards the result
        do_reset();
        ifa.service_req = 16'h0001;
        ifa.result_bus  = pack(3, 3, 3);
        tick();
        check_eq("rack_ack", 64'(ifa.req_ack), 64'h0001);
        rst = 1'b1;
        tick();
        check_eq("rack_ack_clr",  64'(ifa.req_ack),  64'h0);
        check_eq("rack_wren_clr", 64'(ifa.fb_wr_en), 64'h0);
        rst = 1'b0;
        ifa.service_req = 16'h0000;
        tick();
        tick();
        check_eq("rack_no_write", 64'(ifa.fb_wr_en),    64'h0);
        check_eq("rack_pix",      64'(ifa.pixel_count), 64'h0);

        // Frame completion on the 4x2 instance
        for (int i = 0; i < 8; i++) begin
            ifs.service_req = 16'(1 << i);
            ifs.result_bus  = pack(i % 4, i / 4, i + 1);
            tick();
            ifs.service_req = 16'h0000;
            tick();
            check_eq($sformatf("frm_addr_%0d", i), 64'(ifs.fb_addr), 64'(i));
            tick();
            check_eq($sformatf("frm_pix_%0d", i),  64'(ifs.pixel_count), 64'(i + 1));
            check_eq($sformatf("frm_done_%0d", i), 64'(ifs.frame_done),  64'(i == 7));
            tick();
        end
        check_eq("frm_done_pulse", 64'(ifs.frame_done), 64'h0);
        // Saturation: a ninth write is not counted and no second pulse
        ifs.service_req = 16'h0001;
        ifs.result_bus  = pack(0, 0, 1);
        tick();
        ifs.service_req = 16'h0000;
        tick();
        tick();
        check_eq("frm_sat_pix",  64'(ifs.pixel_count), 64'd8);
        check_eq("frm_sat_done", 64'(ifs.frame_done),  64'h0);
        tick();
        // frame_start coincides with an accepted write: clear wins
        ifs.service_req = 16'h0002;
        ifs.result_bus  = pack(1, 1, 1);
        tick();
        ifs.service_req = 16'h0000;
        tick();
        check_eq("fs_wren", 64'(ifs.fb_wr_en), 64'h1);
        ifs.frame_start = 1'b1;
        tick();
        ifs.frame_start = 1'b0;
        check_eq("fs_clear_pix", 64'(ifs.pixel_count), 64'h0);
        tick();
        ifs.service_req = 16'h0004;
        ifs.result_bus  = pack(2, 0, 1);
        tick();
        ifs.service_req = 16'h0000;
        tick();
        tick();
        check_eq("fs_next_pix", 64'(ifs.pixel_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
